// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - opcode, FSM state and APSR bit definitions shared by the execute stage
package exec_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_RSB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_ORR = 4'd6;
  localparam logic [3:0] OP_EOR = 4'd7;
  localparam logic [3:0] OP_BIC = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_MVN = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;
  localparam logic [3:0] OP_CMN = 4'd12;
  localparam logic [3:0] OP_TST = 4'd13;
  localparam logic [3:0] OP_TEQ = 4'd14;
  localparam logic [3:0] OP_MUL = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_e;

  localparam int APSR_N = 4;
  localparam int APSR_Z = 3;
  localparam int APSR_C = 2;
  localparam int APSR_V = 1;
  localparam int APSR_Q = 0;

endpackage

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - iterative multiplier retiring MUL_BITS multiplier bits per cycle
// done is combinational on the final step so the caller can register product on that same edge.
module exec_mul_iter #(
  parameter int MUL_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam int STEPS = 32 / MUL_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      chunk;

  assign chunk   = {{(32-MUL_BITS){1'b0}}, b_q[MUL_BITS-1:0]};
  assign product = acc_q + a_q * chunk;
  assign done    = busy && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      a_q   <= multiplicand;
      b_q   <= multiplier;
      acc_q <= '0;
      cnt_q <= CNT_W'(STEPS);
    end else if (busy) begin
      acc_q <= product;
      b_q   <= b_q >> MUL_BITS;
      cnt_q <= cnt_q - CNT_W'(1);
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_wb_stage.sv
// rtl/exec_wb_stage.sv - execute/writeback stage: ALU, iterative MUL, reg_file write and APSR update
module exec_wb_stage
  import exec_pkg::*;
#(
  parameter int MUL_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [31:0] oprand1,
  input  logic [31:0] oprand2,
  input  logic [3:0]  rd_addr_i,
  input  logic        set_flags,
  input  logic        shift_carry,
  input  logic        apsr_c,
  output logic        rf_w_en,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [4:0]  en_apsr,
  output logic [3:0]  apsr_nzcv
);

  exec_state_e state_q, state_d;
  logic        accept, mul_start, mul_busy, mul_done;
  logic [31:0] mul_product;
  logic [3:0]  mul_rd_q;
  logic        mul_sf_q;

  logic [31:0] add_x, add_y, logic_res, result;
  logic        add_cin, is_arith, is_logic, is_cmp, sf, ovf;
  logic [32:0] sum;
  logic [4:0]  en_alu;
  logic [3:0]  nzcv_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    accept    = in_valid && in_ready;
    mul_start = accept && (opcode == OP_MUL);
  end

  exec_mul_iter #(.MUL_BITS(MUL_BITS)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .multiplicand (oprand1),
    .multiplier   (oprand2),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  // Every subtract form is folded into a single 33-bit add so C and V come out uniformly.
  always_comb begin
    add_x     = oprand1;
    add_y     = oprand2;
    add_cin   = 1'b0;
    logic_res = '0;
    is_arith  = 1'b0;
    is_logic  = 1'b0;
    is_cmp    = 1'b0;
    case (opcode)
      OP_ADD: is_arith = 1'b1;
      OP_ADC: begin is_arith = 1'b1; add_cin = apsr_c; end
      OP_SUB: begin is_arith = 1'b1; add_y = ~oprand2; add_cin = 1'b1; end
      OP_SBC: begin is_arith = 1'b1; add_y = ~oprand2; add_cin = apsr_c; end
      OP_RSB: begin is_arith = 1'b1; add_x = oprand2; add_y = ~oprand1; add_cin = 1'b1; end
      OP_CMP: begin is_arith = 1'b1; is_cmp = 1'b1; add_y = ~oprand2; add_cin = 1'b1; end
      OP_CMN: begin is_arith = 1'b1; is_cmp = 1'b1; end
      OP_AND: begin is_logic = 1'b1; logic_res = oprand1 & oprand2; end
      OP_ORR: begin is_logic = 1'b1; logic_res = oprand1 | oprand2; end
      OP_EOR: begin is_logic = 1'b1; logic_res = oprand1 ^ oprand2; end
      OP_BIC: begin is_logic = 1'b1; logic_res = oprand1 & ~oprand2; end
      OP_MOV: begin is_logic = 1'b1; logic_res = oprand2; end
      OP_MVN: begin is_logic = 1'b1; logic_res = ~oprand2; end
      OP_TST: begin is_logic = 1'b1; is_cmp = 1'b1; logic_res = oprand1 & oprand2; end
      OP_TEQ: begin is_logic = 1'b1; is_cmp = 1'b1; logic_res = oprand1 ^ oprand2; end
      default: ;
    endcase
  end

  always_comb begin
    sum    = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_cin};
    ovf    = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
    result = is_arith ? sum[31:0] : logic_res;
    sf     = set_flags || is_cmp;
    nzcv_alu = {result[31], result == 32'd0,
                is_arith ? sum[32] : shift_carry,
                is_arith ? ovf : 1'b0};
    en_alu         = '0;
    en_alu[APSR_N] = sf;
    en_alu[APSR_Z] = sf;
    en_alu[APSR_C] = sf;
    en_alu[APSR_V] = sf && is_arith;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_w_en   <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      en_apsr   <= '0;
      apsr_nzcv <= '0;
      mul_rd_q  <= '0;
      mul_sf_q  <= 1'b0;
    end else begin
      rf_w_en <= 1'b0;
      en_apsr <= '0;
      if (mul_start) begin
        mul_rd_q <= rd_addr_i;
        mul_sf_q <= set_flags;
      end
      if (mul_done) begin
        rf_w_en   <= 1'b1;
        rd_addr   <= mul_rd_q;
        rd_data   <= mul_product;
        en_apsr   <= {mul_sf_q, mul_sf_q, 3'b000};
        apsr_nzcv <= {mul_product[31], mul_product == 32'd0, 2'b00};
      end else if (accept && (is_arith || is_logic)) begin
        rf_w_en   <= !is_cmp;
        rd_addr   <= rd_addr_i;
        rd_data   <= result;
        en_apsr   <= en_alu;
        apsr_nzcv <= nzcv_alu;
      end
    end
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
// tb/tb_exec_wb_stage.sv - directed self-checking bench for exec_wb_stage
module tb_exec_wb_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [31:0] oprand1 = '0;
  logic [31:0] oprand2 = '0;
  logic [3:0]  rd_addr_i = '0;
  logic        set_flags = 1'b0;
  logic        shift_carry = 1'b0;
  logic        apsr_c = 1'b0;
  logic        rf_w_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  en_apsr;
  logic [3:0]  apsr_nzcv;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_wb_stage #(.MUL_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .oprand1(oprand1), .oprand2(oprand2), .rd_addr_i(rd_addr_i),
    .set_flags(set_flags), .shift_carry(shift_carry), .apsr_c(apsr_c),
    .rf_w_en(rf_w_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .en_apsr(en_apsr), .apsr_nzcv(apsr_nzcv)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, input logic sf, input logic sc);
    in_valid = 1'b1; opcode = op; oprand1 = a; oprand2 = b;
    rd_addr_i = rd; set_flags = sf; shift_carry = sc;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if ({rf_w_en, rd_addr, rd_data, en_apsr, apsr_nzcv} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got w=%b a=%h d=%h en=%b f=%b want all 0",
               rf_w_en, rd_addr, rd_data, en_apsr, apsr_nzcv);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen_w = 0;
    issue(OP_MUL, 32'd7, 32'd9, 4'd6, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midmul_in_ready got %b want 1", in_ready); end
    n_checks++;
    if ({rf_w_en, rd_addr, rd_data, en_apsr, apsr_nzcv} !== '0) begin
      n_fail++;
      $display("FAIL midmul_outputs got w=%b a=%h d=%h en=%b f=%b want all 0",
               rf_w_en, rd_addr, rd_data, en_apsr, apsr_nzcv);
    end
    for (int i = 0; i < 12; i++) begin
      if (rf_w_en === 1'b1) seen_w++;
      step();
    end
    n_checks++;
    if (seen_w != 0) begin n_fail++; $display("FAIL midmul_no_write got %0d writes want 0", seen_w); end
  endtask

  task automatic test_adds();
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (rf_w_en !== 1'b1 || rd_addr !== 4'd1 || rd_data !== 32'h8000_0000) begin
      n_fail++; $display("FAIL adds_write got w=%b a=%h d=%h want 1 1 80000000", rf_w_en, rd_addr, rd_data);
    end
    n_checks++;
    if (apsr_nzcv !== 4'b1001 || en_apsr !== 5'b11110) begin
      n_fail++; $display("FAIL adds_flags got f=%b en=%b want 1001 11110", apsr_nzcv, en_apsr);
    end
    step();
    n_checks++;
    if (rf_w_en !== 1'b0 || en_apsr !== 5'b0) begin
      n_fail++; $display("FAIL adds_pulse got w=%b en=%b want 0 00000", rf_w_en, en_apsr);
    end
  endtask

  task automatic test_subs_cmp();
    issue(OP_SUB, 32'd5, 32'd5, 4'd2, 1'b1, 1'b0);
    step();
    n_checks++;
    if (rf_w_en !== 1'b1 || rd_data !== 32'd0 || apsr_nzcv !== 4'b0110 || en_apsr !== 5'b11110) begin
      n_fail++; $display("FAIL subs got w=%b d=%h f=%b en=%b want 1 0 0110 11110",
                         rf_w_en, rd_data, apsr_nzcv, en_apsr);
    end
    issue(OP_CMP, 32'd3, 32'd5, 4'd3, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (rf_w_en !== 1'b0 || apsr_nzcv !== 4'b1000 || en_apsr !== 5'b11110) begin
      n_fail++; $display("FAIL cmp got w=%b f=%b en=%b want 0 1000 11110", rf_w_en, apsr_nzcv, en_apsr);
    end
  endtask

  task automatic test_ands();
    issue(OP_AND, 32'hF0F0_0000, 32'h0F0F_FFFF, 4'd4, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (rf_w_en !== 1'b1 || rd_data !== 32'd0 || apsr_nzcv[3:1] !== 3'b011 || en_apsr !== 5'b11100) begin
      n_fail++; $display("FAIL ands got w=%b d=%h f=%b en=%b want 1 0 011x 11100",
                         rf_w_en, rd_data, apsr_nzcv, en_apsr);
    end
  endtask

  task automatic test_mul();
    int low = 0;
    int early_w = 0;
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd3, 4'd5, 1'b1, 1'b0);
    step();
    // stage two keeps in_valid high with a different op; it must be ignored
    issue(OP_ADD, 32'd100, 32'd200, 4'd9, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) break;
      if (rf_w_en === 1'b1) early_w++;
      low++;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (low != 8) begin n_fail++; $display("FAIL mul_busy_cycles got %0d want 8", low); end
    n_checks++;
    if (early_w != 0) begin n_fail++; $display("FAIL mul_ignored_valid got %0d writes want 0", early_w); end
    n_checks++;
    if (rf_w_en !== 1'b1 || rd_addr !== 4'd5 || rd_data !== 32'hFFFF_FFFD || en_apsr !== 5'b11000
        || apsr_nzcv[3:2] !== 2'b10) begin
      n_fail++; $display("FAIL mul_result got w=%b a=%h d=%h en=%b f=%b want 1 5 fffffffd 11000 10xx",
                         rf_w_en, rd_addr, rd_data, en_apsr, apsr_nzcv);
    end
    step();
    n_checks++;
    if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL mul_after got w=%b want 0", rf_w_en); end
  endtask

  task automatic test_back_to_back();
    issue(OP_ADD, 32'd1, 32'd2, 4'd2, 1'b0, 1'b0);
    step();
    n_checks++;
    if (rf_w_en !== 1'b1 || rd_addr !== 4'd2 || rd_data !== 32'd3 || en_apsr !== 5'b0) begin
      n_fail++; $display("FAIL b2b_add got w=%b a=%h d=%h en=%b want 1 2 3 0", rf_w_en, rd_addr, rd_data, en_apsr);
    end
    issue(OP_EOR, 32'h0000_00F0, 32'h0000_00FF, 4'd3, 1'b0, 1'b0);
    step();
    n_checks++;
    if (rf_w_en !== 1'b1 || rd_addr !== 4'd3 || rd_data !== 32'h0000_000F) begin
      n_fail++; $display("FAIL b2b_eor got w=%b a=%h d=%h want 1 3 f", rf_w_en, rd_addr, rd_data);
    end
    issue(OP_MOV, 32'd0, 32'h0000_1234, 4'd15, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (rf_w_en !== 1'b1 || rd_addr !== 4'd15 || rd_data !== 32'h0000_1234) begin
      n_fail++; $display("FAIL b2b_mov got w=%b a=%h d=%h want 1 f 1234", rf_w_en, rd_addr, rd_data);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_adds();
    test_subs_cmp();
    test_ands();
    test_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
